vl_strip_sequencer: RTL and testbench

- Strip-mining controller wrapped around the vl computation.
- Accepts one vsetvli-style configuration (SEW, LMUL, AVL), latches vtype, then issues consecutive strips to the vector execute stage until AVL is exhausted.
- Each strip carries vl = min(VLMAX, remaining AVL) over a valid/ready handshake.
- Sits between ID (config source) and the vector lanes; owns the architectural vl/vtype registers.

---
 rtl/vl_strip_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_vl_strip_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vl_strip_sequencer.sv
// rtl/vl_strip_sequencer.sv - strip-mining vl/vtype sequencer; VL_STRIP_PERF_EN adds perf counters
// Latches one vsetvli-style config and issues min(VLMAX, rem) strips until AVL is exhausted.
module vl_strip_sequencer #(
  parameter int VLEN  = 64,
  parameter int AVL_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_sew,
  input  logic [2:0]       cfg_lmul,
  input  logic [AVL_W-1:0] cfg_avl,
  output logic             strip_valid,
  input  logic             strip_ready,
  output logic [AVL_W-1:0] strip_vl,
  output logic             strip_last,
  input  logic             abort,
  output logic [6:0]       vtype,
  output logic [AVL_W-1:0] vl,
  output logic             busy,
  output logic             done,
`ifdef VL_STRIP_PERF_EN
  output logic             cfg_err,
  output logic [7:0]       perf_strips,
  output logic [15:0]      perf_stall
`else
  output logic             cfg_err
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_FIN} state_t;

  state_t           state_q, state_d;
  logic [AVL_W-1:0] rem_q, rem_d;
  logic [AVL_W-1:0] vlmax_q, vlmax_d;
  logic [AVL_W-1:0] vl_q, vl_d;
  logic [AVL_W-1:0] svl_q, svl_d;
  logic             slast_q, slast_d;
  logic             err_q, err_d;
  logic [6:0]       vtype_q, vtype_d;

  logic [AVL_W-1:0] cfg_vlmax;
  logic [AVL_W-1:0] next_rem;
  logic             cfg_fire;
  logic             strip_fire;
  logic             cfg_illegal;

  assign cfg_vlmax   = AVL_W'((VLEN >> ({3'b000, cfg_sew[1:0]} + 5'd3)) << cfg_lmul[1:0]);
  assign cfg_illegal = cfg_sew[2] | cfg_lmul[2];
  assign next_rem    = rem_q - svl_q;

  // cfg_ready is masked by rst so a request held through reset is visibly not taken
  assign cfg_ready   = (state_q == ST_IDLE) && !rst;
  assign strip_valid = (state_q == ST_ISSUE);
  assign strip_vl    = strip_valid ? svl_q : '0;
  assign strip_last  = strip_valid && slast_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign cfg_err     = done && err_q;
  assign vtype       = vtype_q;
  assign vl          = vl_q;

  assign cfg_fire   = cfg_valid && cfg_ready && !abort;
  assign strip_fire = strip_valid && strip_ready && !abort;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    vlmax_d = vlmax_q;
    vl_d    = vl_q;
    svl_d   = svl_q;
    slast_d = slast_q;
    err_d   = err_q;
    vtype_d = vtype_q;
    if (abort) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_fire) begin
            vlmax_d = cfg_vlmax;
            if (cfg_illegal) begin
              vtype_d = '0;
              vl_d    = '0;
              rem_d   = '0;
              err_d   = 1'b1;
              state_d = ST_FIN;
            end else begin
              vtype_d = {1'b1, cfg_sew, cfg_lmul};
              rem_d   = cfg_avl;
              err_d   = 1'b0;
              svl_d   = (cfg_avl >= cfg_vlmax) ? cfg_vlmax : cfg_avl;
              slast_d = (cfg_avl <= cfg_vlmax);
              if (cfg_avl == '0) begin
                vl_d    = '0;
                state_d = ST_FIN;
              end else begin
                state_d = ST_ISSUE;
              end
            end
          end
        end
        ST_ISSUE: begin
          // Next strip is precomputed on the handshake so strips go back to back
          if (strip_fire) begin
            vl_d  = svl_q;
            rem_d = next_rem;
            if (slast_q) begin
              state_d = ST_FIN;
            end else begin
              svl_d   = (next_rem >= vlmax_q) ? vlmax_q : next_rem;
              slast_d = (next_rem <= vlmax_q);
            end
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      vlmax_q <= '0;
      vl_q    <= '0;
      svl_q   <= '0;
      slast_q <= 1'b0;
      err_q   <= 1'b0;
      vtype_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      vlmax_q <= vlmax_d;
      vl_q    <= vl_d;
      svl_q   <= svl_d;
      slast_q <= slast_d;
      err_q   <= err_d;
      vtype_q <= vtype_d;
    end
  end

`ifdef VL_STRIP_PERF_EN
  logic [7:0]  perf_strips_q, perf_strips_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_strips_d = perf_strips_q;
    perf_stall_d  = perf_stall_q;
    if (cfg_fire) begin
      perf_strips_d = '0;
    end else if (strip_fire) begin
      perf_strips_d = perf_strips_q + 8'd1;
    end
    if (strip_valid && !strip_ready && (perf_stall_q != 16'hFFFF)) begin
      perf_stall_d = perf_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_strips_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_strips_q <= perf_strips_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_strips = perf_strips_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_vl_strip_sequencer.sv
// tb/tb_vl_strip_sequencer.sv - directed self-checking bench for vl_strip_sequencer
module tb_vl_strip_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_sew;
  logic [2:0] cfg_lmul;
  logic [6:0] cfg_avl;
  logic       strip_valid;
  logic       strip_ready;
  logic [6:0] strip_vl;
  logic       strip_last;
  logic       abort;
  logic [6:0] vtype;
  logic [6:0] vl;
  logic       busy;
  logic       done;
  logic       cfg_err;
`ifdef VL_STRIP_PERF_EN
  logic [7:0]  perf_strips;
  logic [15:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  vl_strip_sequencer #(.VLEN(64), .AVL_W(7)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sew(cfg_sew), .cfg_lmul(cfg_lmul), .cfg_avl(cfg_avl),
    .strip_valid(strip_valid), .strip_ready(strip_ready), .strip_vl(strip_vl),
    .strip_last(strip_last), .abort(abort), .vtype(vtype), .vl(vl),
    .busy(busy), .done(done),
`ifdef VL_STRIP_PERF_EN
    .cfg_err(cfg_err), .perf_strips(perf_strips), .perf_stall(perf_stall)
`else
    .cfg_err(cfg_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_sew = '0; cfg_lmul = '0; cfg_avl = '0;
    strip_ready = 1'b0; abort = 1'b0;
    #1;
    checks++; if (strip_valid !== 1'b0) begin errors++; $display("FAIL reset_strip_valid got=%0d exp=0", strip_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    checks++; if (done !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL reset_done_err got=%0d/%0d exp=0/0", done, cfg_err); end
    checks++; if (vtype !== 7'd0 || vl !== 7'd0) begin errors++; $display("FAIL reset_vtype_vl got=%0d/%0d exp=0/0", vtype, vl); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready got=%0d exp=0", cfg_ready); end
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_cfg_ready got=%0d exp=1", cfg_ready); end
  endtask

  task automatic test_basic();
    logic [6:0] expv;
    cfg_valid = 1'b1; cfg_sew = 3'b010; cfg_lmul = 3'b000; cfg_avl = 7'd5; strip_ready = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expv = (k < 2) ? 7'd2 : 7'd1;
      checks++; if (strip_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got=%0d exp=1", k, strip_valid); end
      checks++; if (strip_vl !== expv) begin errors++; $display("FAIL basic_vl[%0d] got=%0d exp=%0d", k, strip_vl, expv); end
      checks++; if (strip_last !== (k == 2)) begin errors++; $display("FAIL basic_last[%0d] got=%0d exp=%0d", k, strip_last, (k == 2)); end
      tick();
    end
    checks++; if (done !== 1'b1 || cfg_err !== 1'b0) begin errors++; $display("FAIL basic_done got=%0d/%0d exp=1/0", done, cfg_err); end
    checks++; if (vl !== 7'd1) begin errors++; $display("FAIL basic_vl_final got=%0d exp=1", vl); end
    checks++; if (vtype !== 7'b1010000) begin errors++; $display("FAIL basic_vtype got=%b exp=1010000", vtype); end
    checks++; if (strip_valid !== 1'b0) begin errors++; $display("FAIL basic_fin_valid got=%0d exp=0", strip_valid); end
    tick();
    checks++; if (done !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL basic_idle got=%0d/%0d exp=0/1", done, cfg_ready); end
  endtask

  task automatic test_max_vlmax();
    cfg_valid = 1'b1; cfg_sew = 3'b000; cfg_lmul = 3'b011; cfg_avl = 7'd64; strip_ready = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++; if (strip_valid !== 1'b1 || strip_vl !== 7'd64 || strip_last !== 1'b1) begin errors++; $display("FAIL max_strip got=%0d/%0d/%0d exp=1/64/1", strip_valid, strip_vl, strip_last); end
    tick();
    checks++; if (done !== 1'b1 || vl !== 7'd64) begin errors++; $display("FAIL max_done got=%0d/%0d exp=1/64", done, vl); end
    checks++; if (vtype !== 7'b1000011) begin errors++; $display("FAIL max_vtype got=%b exp=1000011", vtype); end
    tick();
  endtask

  task automatic test_illegal();
    cfg_valid = 1'b1; cfg_sew = 3'b100; cfg_lmul = 3'b000; cfg_avl = 7'd10; strip_ready = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++; if (strip_valid !== 1'b0) begin errors++; $display("FAIL illegal_valid got=%0d exp=0", strip_valid); end
    checks++; if (done !== 1'b1 || cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_pulse got=%0d/%0d exp=1/1", done, cfg_err); end
    checks++; if (vtype !== 7'd0 || vl !== 7'd0) begin errors++; $display("FAIL illegal_regs got=%0d/%0d exp=0/0", vtype, vl); end
    tick();
    checks++; if (done !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_pulse_end got=%0d/%0d exp=0/0", done, cfg_err); end
  endtask

  task automatic test_stall();
    logic [6:0] expv;
    cfg_valid = 1'b1; cfg_sew = 3'b001; cfg_lmul = 3'b001; cfg_avl = 7'd20; strip_ready = 1'b0;
    tick();
    cfg_sew = 3'b100;
    for (int k = 0; k < 3; k++) begin
      expv = (k < 2) ? 7'd8 : 7'd4;
      for (int s = 0; s < 3; s++) begin
        checks++; if (strip_valid !== 1'b1 || strip_vl !== expv) begin errors++; $display("FAIL stall_hold[%0d.%0d] got=%0d/%0d exp=1/%0d", k, s, strip_valid, strip_vl, expv); end
        tick();
      end
      strip_ready = 1'b1;
      checks++; if (strip_vl !== expv || strip_last !== (k == 2)) begin errors++; $display("FAIL stall_strip[%0d] got=%0d/%0d exp=%0d/%0d", k, strip_vl, strip_last, expv, (k == 2)); end
      checks++; if (vtype !== 7'b1001001 || cfg_ready !== 1'b0) begin errors++; $display("FAIL stall_busy_cfg got=%b/%0d exp=1001001/0", vtype, cfg_ready); end
      tick();
      strip_ready = 1'b0;
    end
    cfg_valid = 1'b0;
    checks++; if (done !== 1'b1 || vl !== 7'd4) begin errors++; $display("FAIL stall_done got=%0d/%0d exp=1/4", done, vl); end
`ifdef VL_STRIP_PERF_EN
    checks++; if (perf_stall !== 16'd9) begin errors++; $display("FAIL perf_stall got=%0d exp=9", perf_stall); end
    checks++; if (perf_strips !== 8'd3) begin errors++; $display("FAIL perf_strips got=%0d exp=3", perf_strips); end
`endif
    tick();
  endtask

  task automatic test_abort();
    cfg_valid = 1'b1; cfg_sew = 3'b001; cfg_lmul = 3'b001; cfg_avl = 7'd20; strip_ready = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++; if (strip_vl !== 7'd8) begin errors++; $display("FAIL abort_first got=%0d exp=8", strip_vl); end
    tick();
    checks++; if (vl !== 7'd8 || strip_valid !== 1'b1) begin errors++; $display("FAIL abort_second_offer got=%0d/%0d exp=8/1", vl, strip_valid); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (strip_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle got=%0d/%0d/%0d exp=0/0/0", strip_valid, busy, done); end
    checks++; if (vl !== 7'd8 || vtype !== 7'b1001001) begin errors++; $display("FAIL abort_keep got=%0d/%b exp=8/1001001", vl, vtype); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_cfg_ready got=%0d exp=1", cfg_ready); end
    cfg_valid = 1'b1; cfg_sew = 3'b010; cfg_lmul = 3'b000; cfg_avl = 7'd3;
    tick();
    cfg_valid = 1'b0;
    checks++; if (strip_valid !== 1'b1 || strip_vl !== 7'd2 || strip_last !== 1'b0) begin errors++; $display("FAIL abort_newcfg got=%0d/%0d/%0d exp=1/2/0", strip_valid, strip_vl, strip_last); end
    tick();
    checks++; if (strip_vl !== 7'd1 || strip_last !== 1'b1) begin errors++; $display("FAIL abort_newcfg2 got=%0d/%0d exp=1/1", strip_vl, strip_last); end
    tick();
    checks++; if (done !== 1'b1 || vl !== 7'd1) begin errors++; $display("FAIL abort_newdone got=%0d/%0d exp=1/1", done, vl); end
`ifdef VL_STRIP_PERF_EN
    checks++; if (perf_strips !== 8'd2) begin errors++; $display("FAIL abort_perf_strips got=%0d exp=2", perf_strips); end
`endif
    tick();
  endtask

  task automatic test_async_rst();
    cfg_valid = 1'b1; cfg_sew = 3'b010; cfg_lmul = 3'b000; cfg_avl = 7'd5; strip_ready = 1'b0;
    tick();
    cfg_valid = 1'b0;
    checks++; if (strip_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL arst_pre got=%0d/%0d exp=1/1", strip_valid, busy); end
    #2;
    rst = 1'b1;
    cfg_valid = 1'b1; cfg_sew = 3'b000; cfg_lmul = 3'b011; cfg_avl = 7'd64;
    #1;
    checks++; if (strip_valid !== 1'b0 || strip_vl !== 7'd0 || strip_last !== 1'b0) begin errors++; $display("FAIL arst_strip got=%0d/%0d/%0d exp=0/0/0", strip_valid, strip_vl, strip_last); end
    checks++; if (vtype !== 7'd0 || vl !== 7'd0 || busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0 || cfg_ready !== 1'b0) begin errors++; $display("FAIL arst_regs got=%0d/%0d/%0d/%0d/%0d/%0d exp=0/0/0/0/0/0", vtype, vl, busy, done, cfg_err, cfg_ready); end
`ifdef VL_STRIP_PERF_EN
    checks++; if (perf_stall !== 16'd0 || perf_strips !== 8'd0) begin errors++; $display("FAIL arst_perf got=%0d/%0d exp=0/0", perf_stall, perf_strips); end
`endif
    tick(); tick();
    checks++; if (busy !== 1'b0 || strip_valid !== 1'b0) begin errors++; $display("FAIL arst_held got=%0d/%0d exp=0/0", busy, strip_valid); end
    rst = 1'b0; strip_ready = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++; if (strip_valid !== 1'b1 || strip_vl !== 7'd64 || strip_last !== 1'b1) begin errors++; $display("FAIL arst_after got=%0d/%0d/%0d exp=1/64/1", strip_valid, strip_vl, strip_last); end
    tick();
    checks++; if (done !== 1'b1 || vl !== 7'd64) begin errors++; $display("FAIL arst_done got=%0d/%0d exp=1/64", done, vl); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_vlmax();
    test_illegal();
    test_stall();
    test_abort();
    test_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
